// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store access unit: access sizes, FSM states
// and the unshifted byte-enable pattern for each access size.
package mem_access_unit_pkg;

  localparam int LSU_DATA_W = 64;
  localparam int LSU_ADDR_W = 64;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Byte enables for an access of the given size starting at byte 0.
  function automatic logic [7:0] lsu_base_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      LSU_SIZE_B: mask = 8'h01;
      LSU_SIZE_H: mask = 8'h03;
      LSU_SIZE_W: mask = 8'h0F;
      LSU_SIZE_D: mask = 8'hFF;
      default:    mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles for the two sides of the access unit: the pipeline request/response
// channel (master = pipeline, slave = unit) and the data memory port
// (master = unit, slave = memory).
interface mem_access_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

interface mem_port_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational alignment helper: misalignment check on the incoming request,
// store data/byte-enable placement within the 64-bit beat, and load byte
// extraction with sign or zero extension.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]            chk_size,
  input  logic [2:0]            chk_off,
  output logic                  misaligned,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [2:0]            off,
  input  logic [LSU_DATA_W-1:0] wdata,
  input  logic [LSU_DATA_W-1:0] rdata,
  output logic [LSU_DATA_W-1:0] wdata_sh,
  output logic [7:0]            wmask,
  output logic [LSU_DATA_W-1:0] rdata_ext
);

  logic [LSU_DATA_W-1:0] rd_sh_s;

  assign wdata_sh = wdata << {off, 3'b000};
  assign wmask    = lsu_base_mask(size) << off;
  assign rd_sh_s  = rdata >> {off, 3'b000};

  // A half/word/dword must start on its natural boundary; bytes never fault.
  always_comb begin
    misaligned = 1'b0;
    case (chk_size)
      LSU_SIZE_B: misaligned = 1'b0;
      LSU_SIZE_H: misaligned = chk_off[0];
      LSU_SIZE_W: misaligned = |chk_off[1:0];
      LSU_SIZE_D: misaligned = |chk_off;
      default:    misaligned = 1'b0;
    endcase
  end

  // Take the addressed bytes and extend from their top bit unless unsigned.
  always_comb begin
    rdata_ext = 64'd0;
    case (size)
      LSU_SIZE_B: rdata_ext = {{56{~is_unsigned & rd_sh_s[7]}}, rd_sh_s[7:0]};
      LSU_SIZE_H: rdata_ext = {{48{~is_unsigned & rd_sh_s[15]}}, rd_sh_s[15:0]};
      LSU_SIZE_W: rdata_ext = {{32{~is_unsigned & rd_sh_s[31]}}, rd_sh_s[31:0]};
      LSU_SIZE_D: rdata_ext = rd_sh_s;
      default:    rdata_ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one pipeline memory op, issues it as a single
// aligned 64-bit beat, waits for the memory answer and returns one response
// pulse. Misaligned ops are answered with an error without touching memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = LSU_ADDR_W
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave core,
  mem_port_if.master       mem
);

  lsu_state_e        state_r, state_s;
  logic              we_r, uns_r, err_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic              mis_s, capture_s, accept_s;
  logic [DATA_W-1:0] wdata_sh_s, rdata_ext_s;
  logic [7:0]        wmask_s;

  lsu_align u_align (
    .chk_size   (core.req_size),
    .chk_off    (core.req_addr[2:0]),
    .misaligned (mis_s),
    .size       (size_r),
    .is_unsigned(uns_r),
    .off        (addr_r[2:0]),
    .wdata      (wdata_r),
    .rdata      (mem.mem_rdata),
    .wdata_sh   (wdata_sh_s),
    .wmask      (wmask_s),
    .rdata_ext  (rdata_ext_s)
  );

  assign accept_s  = (state_r == LSU_IDLE) & core.req_valid;
  assign capture_s = ((state_r == LSU_REQ) & mem.mem_gnt & mem.mem_rvalid) |
                     ((state_r == LSU_WAIT) & mem.mem_rvalid);

  assign mem.mem_addr  = {addr_r[ADDR_W-1:3], 3'b000};
  assign mem.mem_wdata = wdata_sh_s;
  assign core.resp_rdata = rdata_r;
  assign core.resp_err   = err_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and state-driven handshake outputs.
  always_comb begin
    state_s         = state_r;
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    core.stall      = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_wmask   = 8'h00;
    case (state_r)
      LSU_IDLE: begin
        core.req_ready = 1'b1;
        core.stall     = core.req_valid;
        if (core.req_valid) begin
          if (mis_s) begin
            state_s = LSU_DONE;
          end else begin
            state_s = LSU_REQ;
          end
        end else begin
          state_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        core.stall    = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_r;
        mem.mem_wmask = wmask_s;
        if (mem.mem_gnt) begin
          if (mem.mem_rvalid) begin
            state_s = LSU_DONE;
          end else begin
            state_s = LSU_WAIT;
          end
        end else begin
          state_s = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        core.stall = 1'b1;
        if (mem.mem_rvalid) begin
          state_s = LSU_DONE;
        end else begin
          state_s = LSU_WAIT;
        end
      end
      LSU_DONE: begin
        core.resp_valid = 1'b1;
        state_s         = LSU_IDLE;
      end
      default: begin
        state_s = LSU_IDLE;
      end
    endcase
  end

  // Request capture on accept and response data capture on the memory answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r    <= core.req_we;
      uns_r   <= core.req_unsigned;
      size_r  <= core.req_size;
      addr_r  <= core.req_addr;
      wdata_r <= core.req_wdata;
      rdata_r <= '0;
      err_r   <= mis_s;
    end else if (capture_s) begin
      rdata_r <= we_r ? '0 : rdata_ext_s;
      err_r   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: the stimulus process acts as pipeline
// and memory, pushes the expected response of each op into a queue, and an
// independent monitor pops and compares every response pulse.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  resp_t exp_q[$];
  logic [63:0] phys_mem [logic [60:0]];
  logic [63:0] ref_mem  [logic [60:0]];

  always #5 clk = ~clk;

  mem_access_unit_if core_if ();
  mem_port_if        mem_if ();

  mem_access_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .core (core_if),
    .mem  (mem_if)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load: pick nbytes starting at byte off, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off,
                                           input int nbytes, input logic uns);
    logic [63:0] m, v;
    m = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v = (word >> (8 * off)) & m;
    if (!uns && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic touch_word(input logic [60:0] idx);
    logic [63:0] w;
    if (!phys_mem.exists(idx)) begin
      w = {$urandom(), $urandom()};
      phys_mem[idx] = w;
      ref_mem[idx]  = w;
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (core_if.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", core_if.resp_rdata, e.rdata);
        chk("resp_err", {63'd0, core_if.resp_err}, {63'd0, e.err});
      end
    end
  end

  // One complete op: pipeline issue, memory grant/answer, latency checks.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int gnt_dly, input bit same, input int rv_dly);
    int nb, off;
    bit mis;
    logic [60:0] idx;
    logic [15:0] mask16;
    logic [63:0] w;
    resp_t e;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    mis = (off % nb) != 0;
    idx = addr[63:3];
    mask16 = ((16'd1 << nb) - 16'd1) << off;
    touch_word(idx);
    if (mis) begin
      e.rdata = 64'd0; e.err = 1'b1;
    end else if (we) begin
      w = ref_mem[idx];
      for (int b = 0; b < nb; b++) w[8 * (off + b) +: 8] = wdata[8 * b +: 8];
      ref_mem[idx] = w;
      e.rdata = 64'd0; e.err = 1'b0;
    end else begin
      e.rdata = ref_load(ref_mem[idx], off, nb, uns); e.err = 1'b0;
    end
    exp_q.push_back(e);

    core_if.req_valid = 1'b1; core_if.req_we = we; core_if.req_size = size;
    core_if.req_unsigned = uns; core_if.req_addr = addr; core_if.req_wdata = wdata;
    @(negedge clk);
    chk("idle_ready", {63'd0, core_if.req_ready}, 64'd1);
    chk("idle_stall", {63'd0, core_if.stall}, 64'd1);
    @(posedge clk); #1;
    core_if.req_valid = 1'b0;
    core_if.req_addr  = {$urandom(), $urandom()};
    core_if.req_wdata = {$urandom(), $urandom()};
    if (mis) begin
      @(negedge clk);
      chk("mis_resp_valid", {63'd0, core_if.resp_valid}, 64'd1);
      chk("mis_mem_req", {63'd0, mem_if.mem_req}, 64'd0);
      chk("mis_stall", {63'd0, core_if.stall}, 64'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        if (i == gnt_dly) begin
          mem_if.mem_gnt = 1'b1;
          if (same) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = phys_mem[idx];
          end
        end
        @(negedge clk);
        chk("req_mem_req", {63'd0, mem_if.mem_req}, 64'd1);
        chk("req_mem_we", {63'd0, mem_if.mem_we}, {63'd0, we});
        chk("req_mem_addr", mem_if.mem_addr, addr & ~64'd7);
        chk("req_mem_wmask", {56'd0, mem_if.mem_wmask}, {56'd0, mask16[7:0]});
        if (we) chk("req_mem_wdata", mem_if.mem_wdata, wdata << (8 * off));
        chk("req_stall", {63'd0, core_if.stall}, 64'd1);
        chk("req_no_resp", {63'd0, core_if.resp_valid}, 64'd0);
        if (i == gnt_dly && mem_if.mem_we === 1'b1) begin
          w = phys_mem[idx];
          for (int b = 0; b < 8; b++)
            if (mem_if.mem_wmask[b]) w[8 * b +: 8] = mem_if.mem_wdata[8 * b +: 8];
          phys_mem[idx] = w;
        end
        @(posedge clk); #1;
      end
      mem_if.mem_gnt = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      if (!same) begin
        for (int j = 0; j < rv_dly; j++) begin
          @(negedge clk);
          chk("wait_mem_req", {63'd0, mem_if.mem_req}, 64'd0);
          chk("wait_stall", {63'd0, core_if.stall}, 64'd1);
          @(posedge clk); #1;
        end
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = phys_mem[idx];
        @(posedge clk); #1;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = {$urandom(), $urandom()};
      end
      @(negedge clk);
      chk("done_resp_valid", {63'd0, core_if.resp_valid}, 64'd1);
      chk("done_stall", {63'd0, core_if.stall}, 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    core_if.req_valid = 1'b0; core_if.req_we = 1'b0; core_if.req_size = 2'd0;
    core_if.req_unsigned = 1'b0; core_if.req_addr = 64'd0; core_if.req_wdata = 64'd0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 64'd0;
    phys_mem[61'h200] = 64'h8000_0001_F034_5678;
    ref_mem[61'h200]  = 64'h8000_0001_F034_5678;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, core_if.req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, core_if.resp_valid}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_if.mem_req}, 64'd0);
    chk("rst_mem_wmask", {56'd0, mem_if.mem_wmask}, 64'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 64'd0);
    chk("rst_stall", {63'd0, core_if.stall}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, LSU_SIZE_W, 1'b0, 64'h1004, 64'd0, 0, 1'b0, 0);
    do_op(1'b0, LSU_SIZE_B, 1'b1, 64'h1003, 64'd0, 0, 1'b0, 0);
    do_op(1'b0, LSU_SIZE_B, 1'b0, 64'h1003, 64'd0, 1, 1'b0, 0);
    do_op(1'b1, LSU_SIZE_H, 1'b0, 64'h2006, 64'hBEEF, 0, 1'b0, 1);
    do_op(1'b0, LSU_SIZE_W, 1'b0, 64'h1002, 64'd0, 0, 1'b0, 0);
    do_op(1'b0, LSU_SIZE_D, 1'b0, 64'h1000, 64'd0, 5, 1'b1, 0);
    do_op(1'b0, LSU_SIZE_H, 1'b0, 64'h2006, 64'd0, 0, 1'b0, 0);
    do_op(1'b0, LSU_SIZE_W, 1'b1, 64'h1004, 64'd0, 2, 1'b1, 0);

    // Reset while waiting for read data; the late answer must be dropped.
    core_if.req_valid = 1'b1; core_if.req_we = 1'b0; core_if.req_size = LSU_SIZE_D;
    core_if.req_addr = 64'h1000;
    @(posedge clk); #1;
    core_if.req_valid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_before_rst_stall", {63'd0, core_if.stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_mem_req", {63'd0, mem_if.mem_req}, 64'd0);
    chk("rst_wait_ready", {63'd0, core_if.req_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    mem_if.mem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_rvalid_no_resp", {63'd0, core_if.resp_valid}, 64'd0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'h3000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            {$urandom(), $urandom()}, int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
